// File: rtl/fu_scalar_lsq_pkg.sv
// Shared types and lane helpers for the scalar load/store queue.
package fu_scalar_lsq_pkg;

  localparam int LSQ_WORD_W = 32;
  localparam int LSQ_RD_W   = 5;

  typedef logic [LSQ_WORD_W-1:0] word_t;
  typedef logic [LSQ_RD_W-1:0]   regbits_t;

  typedef enum logic [1:0] {dhit_na = 2'd0, dhit_load = 2'd1, dhit_store = 2'd2} dhit_t;
  typedef enum logic [1:0] {NONE = 2'd0, LOAD = 2'd1, STORE = 2'd2} mem_type_t;
  typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} ls_size_t;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, FAULT = 2'd2} lsq_state_t;

  typedef struct packed {
    word_t     addr;
    ls_size_t  size;
    logic      is_unsigned;
    word_t     data;
    regbits_t  rd;
    mem_type_t mtype;
    logic      misaligned;
  } lsq_entry_t;

  function automatic logic is_misaligned(ls_size_t sz, logic [1:0] lo);
    case (sz)
      BYTE:    return 1'b0;
      HALF:    return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(ls_size_t sz, logic [1:0] lo);
    case (sz)
      BYTE:    return 4'b0001 << lo;
      HALF:    return 4'b0011 << lo;
      default: return 4'b1111;
    endcase
  endfunction

  // A head that is already known to be misaligned never reaches the memory port.
  function automatic lsq_state_t state_for(lsq_entry_t e);
    return e.misaligned ? FAULT : ISSUE;
  endfunction

endpackage

// File: rtl/fu_scalar_lsq_fifo.sv
// In-order circular buffer of LSQ entries; flush can optionally retain the head.
module fu_scalar_lsq_fifo
  import fu_scalar_lsq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     i_push,
  input  lsq_entry_t               i_entry,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic                     i_keep_head,
  output lsq_entry_t               o_head,
  output lsq_entry_t               o_second,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;

  lsq_entry_t r_mem [DEPTH];
  ptr_t       r_rptr;
  ptr_t       r_wptr;
  cnt_t       r_count;
  logic       w_keep;

  assign w_keep = i_keep_head && !i_pop && (r_count != '0);

  // NOTE: every register here uses <= so all updates see the pre-edge values.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      // NOTE: the storage array is cleared too, so no stale entry survives reset.
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_mem[r_wptr] <= i_entry;
      if (i_pop)  r_rptr <= r_rptr + ptr_t'(1);
      if (i_flush) begin
        r_wptr  <= w_keep ? r_rptr + ptr_t'(1) : r_rptr + ptr_t'(i_pop);
        r_count <= w_keep ? cnt_t'(1) : '0;
      end else begin
        if (i_push) r_wptr <= r_wptr + ptr_t'(1);
        r_count <= r_count + cnt_t'(i_push) - cnt_t'(i_pop);
      end
    end
  end

  assign o_head   = r_mem[r_rptr];
  assign o_second = r_mem[r_rptr + ptr_t'(1)];
  assign o_count  = r_count;
  assign o_full   = (r_count == cnt_t'(DEPTH));
  assign o_empty  = (r_count == '0);

endmodule

// File: rtl/fu_scalar_lsq.sv
// Scalar load/store unit: in-order request queue feeding a single-ported dmem.
// Define FU_SCALAR_LSQ_PERF_EN to add saturating stall/access counters.
module fu_scalar_lsq
  import fu_scalar_lsq_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WORD_W = LSQ_WORD_W,
  parameter int RD_W   = LSQ_RD_W
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        mem_type,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [WORD_W-1:0] rs1,
  input  logic [WORD_W-1:0] rs2,
  input  logic [WORD_W-1:0] imm,
  input  logic [RD_W-1:0]   rd_in,
  input  logic              flush,
  output logic [WORD_W-1:0] dmemaddr,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [3:0]        dmembyteen,
  output logic [WORD_W-1:0] dmemstore,
  input  logic              dhit_in,
  input  logic [WORD_W-1:0] dmem_in,
  output logic              resp_valid,
  output logic [1:0]        dhit,
  output logic [RD_W-1:0]   rd,
  output logic [WORD_W-1:0] dmemload,
  output logic              misaligned
`ifdef FU_SCALAR_LSQ_PERF_EN
  ,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_accesses
`endif
);

  typedef logic [$clog2(DEPTH):0] cnt_t;

  lsq_state_t r_state;
  lsq_state_t w_state_n;
  lsq_state_t w_after_pop;
  lsq_entry_t w_new;
  lsq_entry_t w_head;
  lsq_entry_t w_second;
  cnt_t       w_count;
  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  dhit_t      w_dhit;
  word_t      w_load_sh;
  word_t      w_load_ext;
  word_t      w_store_lane;

  assign req_ready = !w_full;
  assign w_push    = req_valid && req_ready && (mem_type != NONE) && !flush;

  always_comb begin
    w_new             = '0;
    w_new.addr        = rs1 + imm;
    w_new.size        = ls_size_t'(size);
    w_new.is_unsigned = is_unsigned;
    w_new.data        = rs2;
    w_new.rd          = rd_in;
    w_new.mtype       = (mem_type == STORE) ? STORE : LOAD;
    w_new.misaligned  = is_misaligned(w_new.size, w_new.addr[1:0]);
  end

  fu_scalar_lsq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK        (CLK),
    .nRST       (nRST),
    .i_push     (w_push),
    .i_entry    (w_new),
    .i_pop      (w_pop),
    .i_flush    (flush),
    .i_keep_head(r_state == ISSUE),
    .o_head     (w_head),
    .o_second   (w_second),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // Lane steering: replicate store data across lanes, pick load bytes by address.
  always_comb begin
    case (w_head.size)
      BYTE:    w_store_lane = {4{w_head.data[7:0]}};
      HALF:    w_store_lane = {2{w_head.data[15:0]}};
      default: w_store_lane = w_head.data;
    endcase
    w_load_sh = dmem_in >> {w_head.addr[1:0], 3'b000};
    case (w_head.size)
      BYTE:    w_load_ext = w_head.is_unsigned ? {24'b0, w_load_sh[7:0]}
                                               : {{24{w_load_sh[7]}}, w_load_sh[7:0]};
      HALF:    w_load_ext = w_head.is_unsigned ? {16'b0, w_load_sh[15:0]}
                                               : {{16{w_load_sh[15]}}, w_load_sh[15:0]};
      default: w_load_ext = w_load_sh;
    endcase
  end

  // Where to go once the head retires: straight to the next entry, no bubble.
  always_comb begin
    if (flush)                     w_after_pop = IDLE;
    else if (w_count > cnt_t'(1))  w_after_pop = state_for(w_second);
    else if (w_push)               w_after_pop = state_for(w_new);
    else                           w_after_pop = IDLE;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_state_n;
  end

  // NOTE: every output and next-state value gets a default first, so no latches.
  always_comb begin
    w_state_n  = r_state;
    w_pop      = 1'b0;
    w_dhit     = dhit_na;
    resp_valid = 1'b0;
    rd         = '0;
    dmemload   = '0;
    misaligned = 1'b0;
    dmemaddr   = '0;
    dmemREN    = 1'b0;
    dmemWEN    = 1'b0;
    dmembyteen = '0;
    dmemstore  = '0;
    case (r_state)
      IDLE: begin
        if (!flush) begin
          if (!w_empty)    w_state_n = state_for(w_head);
          else if (w_push) w_state_n = state_for(w_new);
        end
      end
      ISSUE: begin
        dmemaddr   = {w_head.addr[WORD_W-1:2], 2'b00};
        dmembyteen = byte_en(w_head.size, w_head.addr[1:0]);
        dmemREN    = (w_head.mtype == LOAD);
        dmemWEN    = (w_head.mtype == STORE);
        dmemstore  = w_store_lane;
        if (dhit_in) begin
          resp_valid = 1'b1;
          w_pop      = 1'b1;
          w_state_n  = w_after_pop;
          if (w_head.mtype == LOAD) begin
            w_dhit   = dhit_load;
            rd       = w_head.rd;
            dmemload = w_load_ext;
          end else begin
            w_dhit   = dhit_store;
          end
        end
      end
      FAULT: begin
        resp_valid = 1'b1;
        misaligned = 1'b1;
        rd         = w_head.rd;
        w_pop      = 1'b1;
        w_state_n  = w_after_pop;
      end
      default: w_state_n = IDLE;
    endcase
  end

  assign dhit = w_dhit;

`ifdef FU_SCALAR_LSQ_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_acc;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_perf_stall <= '0;
      r_perf_acc   <= '0;
    end else if (r_state == ISSUE) begin
      if (!dhit_in && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
      if (dhit_in && (r_perf_acc != '1))    r_perf_acc   <= r_perf_acc + 32'd1;
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_accesses     = r_perf_acc;
`endif

endmodule

// File: tb/tb_fu_scalar_lsq.sv
// Scoreboard bench for fu_scalar_lsq: a request model feeds an expected queue, a monitor compares.
module tb_fu_scalar_lsq;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  mem_type = 2'd0;
  logic [1:0]  size = 2'd0;
  logic        is_unsigned = 1'b0;
  logic [31:0] rs1 = '0, rs2 = '0, imm = '0;
  logic [4:0]  rd_in = '0;
  logic        flush = 1'b0;
  logic [31:0] dmemaddr, dmemstore, dmem_in, dmemload;
  logic        dmemREN, dmemWEN, dhit_in = 1'b0, resp_valid, misaligned;
  logic [3:0]  dmembyteen;
  logic [1:0]  dhit;
  logic [4:0]  rd;

  int checks = 0;
  int failures = 0;
  int dhit_mode = 0;  // 0 low, 1 high, 2 random

  typedef struct {
    bit          fault;
    bit          is_load;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] sdata;
    logic [31:0] ldata;
    logic [4:0]  rd;
  } exp_t;

  exp_t exp_q[$];

  fu_scalar_lsq dut (
    .CLK(CLK), .nRST(nRST), .req_valid(req_valid), .req_ready(req_ready),
    .mem_type(mem_type), .size(size), .is_unsigned(is_unsigned),
    .rs1(rs1), .rs2(rs2), .imm(imm), .rd_in(rd_in), .flush(flush),
    .dmemaddr(dmemaddr), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmembyteen(dmembyteen), .dmemstore(dmemstore), .dhit_in(dhit_in),
    .dmem_in(dmem_in), .resp_valid(resp_valid), .dhit(dhit), .rd(rd),
    .dmemload(dmemload), .misaligned(misaligned)
  );

  always #5 CLK = ~CLK;

  // Memory contents are a fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'h80FF_FFFF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  assign dmem_in = mem_word(dmemaddr);

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m = '0;
    for (int i = 0; i < 4; i++) if (be[i]) m = m | (32'hFF << (8 * i));
    return m;
  endfunction

  function automatic exp_t model(input logic [1:0] t, input logic [1:0] sz, input logic u,
                                 input logic [31:0] a1, input logic [31:0] d,
                                 input logic [31:0] im, input logic [4:0] r);
    exp_t e;
    logic [31:0] a, w, v;
    int k;
    a = a1 + im;
    k = int'(a % 32'd4);
    e.fault   = (sz == 2'd1 && (a % 32'd2) == 32'd1) || (sz == 2'd2 && k != 0);
    e.is_load = (t != 2'd2);
    e.addr    = a - 32'(k);
    e.rd      = r;
    w = mem_word(e.addr);
    case (sz)
      2'd0: begin
        e.be = 4'(32'd1 << k);
        v = (w >> (8 * k)) % 32'd256;
        if (!u && v >= 32'd128) v = v - 32'd256;
        e.sdata = (d % 32'd256) << (8 * k);
      end
      2'd1: begin
        e.be = 4'(32'd3 << k);
        v = (w >> (8 * k)) % 32'd65536;
        if (!u && v >= 32'd32768) v = v - 32'd65536;
        e.sdata = (d % 32'd65536) << (8 * k);
      end
      default: begin
        e.be = 4'hF;
        v = w;
        e.sdata = d;
      end
    endcase
    e.ldata = v;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, want, $time);
    end
  endtask

  // Monitor + model update, all on the falling edge while inputs are stable.
  always @(negedge CLK) begin : monitor
    exp_t e;
    if (dmemREN === 1'b1 || dmemWEN === 1'b1) begin
      if (exp_q.size() == 0) check("strobe_without_request", {dmemREN, dmemWEN}, 2'b00);
      else begin
        e = exp_q[0];
        if (e.fault) check("fault_no_strobe", {dmemREN, dmemWEN}, 2'b00);
        else begin
          check("strobe_kind", {dmemREN, dmemWEN}, e.is_load ? 2'b10 : 2'b01);
          check("dmemaddr", dmemaddr, e.addr);
          check("dmembyteen", dmembyteen, e.be);
          if (!e.is_load) check("dmemstore", dmemstore & lane_mask(e.be), e.sdata);
        end
      end
    end
    if (resp_valid === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_resp", resp_valid, 1'b0);
      else begin
        e = exp_q.pop_front();
        if (e.fault) begin
          check("fault_misaligned", misaligned, 1'b1);
          check("fault_dhit", dhit, 2'd0);
          check("fault_rd", rd, e.rd);
        end else begin
          check("resp_misaligned", misaligned, 1'b0);
          check("resp_dhit", dhit, e.is_load ? 2'd1 : 2'd2);
          if (e.is_load) begin
            check("resp_rd", rd, e.rd);
            check("dmemload", dmemload, e.ldata);
          end
        end
      end
    end
    if (nRST === 1'b0) exp_q.delete();
    else begin
      if (flush) begin
        if ((dmemREN || dmemWEN) && !dhit_in && exp_q.size() > 0) begin
          e = exp_q[0];
          exp_q.delete();
          exp_q.push_back(e);
        end else exp_q.delete();
      end
      if (req_valid && req_ready && mem_type != 2'd0 && !flush)
        exp_q.push_back(model(mem_type, size, is_unsigned, rs1, rs2, imm, rd_in));
    end
  end

  always @(posedge CLK) begin
    #1;
    case (dhit_mode)
      0:       dhit_in = 1'b0;
      1:       dhit_in = 1'b1;
      default: dhit_in = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input logic [1:0] t, input logic [1:0] sz, input logic u,
                         input logic [31:0] a1, input logic [31:0] d,
                         input logic [31:0] im, input logic [4:0] r);
    mem_type = t; size = sz; is_unsigned = u; rs1 = a1; rs2 = d; imm = im; rd_in = r;
  endtask

  task automatic enq(input logic [1:0] t, input logic [1:0] sz, input logic u,
                     input logic [31:0] a1, input logic [31:0] d,
                     input logic [31:0] im, input logic [4:0] r);
    int n = 0;
    set_req(t, sz, u, a1, d, im, r);
    req_valid = 1'b1;
    while (!req_ready && n < 200) begin
      tick();
      n++;
    end
    if (!req_ready) check("enq_ready_timeout", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    dhit_mode = 1;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
    repeat (2) tick();
  endtask

  task automatic count_resps(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(negedge CLK);
      if (resp_valid === 1'b1) cnt++;
    end
  endtask

  initial begin
    int n;
    int r;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_strobes", {dmemREN, dmemWEN, dmembyteen}, 6'd0);
    check("rst_dmemaddr", dmemaddr, 32'd0);
    check("rst_dhit_rd_mis", {dhit, rd, misaligned}, 8'd0);
    tick();
    nRST = 1'b1;

    // Word store held until dhit_in.
    dhit_mode = 0;
    enq(2'd2, 2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'd4, 5'd0);
    repeat (3) tick();
    drain(50);

    // Signed and unsigned byte loads from lane 3.
    enq(2'd1, 2'd0, 1'b0, 32'h100, 32'd0, 32'd3, 5'd7);
    enq(2'd1, 2'd0, 1'b1, 32'h100, 32'd0, 32'd3, 5'd8);
    drain(50);

    // Fill the queue with the memory stalled, then release.
    dhit_mode = 0;
    enq(2'd1, 2'd2, 1'b0, 32'h40, 32'd0, 32'd0, 5'd1);
    enq(2'd2, 2'd1, 1'b0, 32'h44, 32'h1234_5678, 32'd2, 5'd2);
    enq(2'd1, 2'd1, 1'b0, 32'h48, 32'd0, 32'd2, 5'd3);
    enq(2'd2, 2'd0, 1'b0, 32'h4C, 32'h0000_00A5, 32'd1, 5'd4);
    @(negedge CLK);
    check("full_ready_low", req_ready, 1'b0);
    dhit_mode = 1;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (resp_valid !== 1'b1 && n < 20);
    check("first_resp_seen", resp_valid, 1'b1);
    @(negedge CLK);
    check("ready_after_first", req_ready, 1'b1);
    drain(50);

    // Misaligned half load followed by a normal load.
    dhit_mode = 2;
    enq(2'd1, 2'd1, 1'b0, 32'h200, 32'd0, 32'd1, 5'd9);
    enq(2'd1, 2'd2, 1'b0, 32'h300, 32'd0, 32'd0, 5'd10);
    drain(50);

    // Flush with three entries while the head is stalled in issue.
    dhit_mode = 0;
    enq(2'd1, 2'd2, 1'b0, 32'h500, 32'd0, 32'd0, 5'd11);
    enq(2'd2, 2'd2, 1'b0, 32'h504, 32'h5555_AAAA, 32'd0, 5'd12);
    enq(2'd1, 2'd0, 1'b1, 32'h508, 32'd0, 32'd1, 5'd13);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    dhit_mode = 1;
    count_resps(10, n);
    check("flush_resp_count", n, 1);
    check("flush_ready", req_ready, 1'b1);

    // Reset in the middle of a stalled access with a full queue.
    dhit_mode = 0;
    for (int i = 0; i < 4; i++) enq(2'd1, 2'd2, 1'b0, 32'h600 + 32'(4 * i), 32'd0, 32'd0, 5'(i));
    tick();
    nRST = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("midrst_req_ready", req_ready, 1'b1);
    check("midrst_resp_valid", resp_valid, 1'b0);
    check("midrst_strobes", {dmemREN, dmemWEN, dmembyteen}, 6'd0);
    check("midrst_data", dmemaddr | dmemstore | dmemload, 32'd0);
    check("midrst_dhit_rd_mis", {dhit, rd, misaligned}, 8'd0);
    tick();
    nRST = 1'b1;
    dhit_mode = 1;
    count_resps(10, n);
    check("post_reset_no_resp", n, 0);

    // Randomized traffic with random memory latency and occasional flushes.
    dhit_mode = 2;
    for (int it = 0; it < 1500; it++) begin
      r = int'($urandom_range(0, 99));
      if (r < 55) begin
        enq(2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : 32'h100 + 32'($urandom_range(0, 63)),
            $urandom, 32'($urandom_range(0, 15)), 5'($urandom_range(0, 31)));
      end else if (r < 60) begin
        set_req(2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)), 1'b0,
                32'h180, $urandom, 32'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
        req_valid = 1'($urandom_range(0, 1));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        req_valid = 1'b0;
      end else begin
        tick();
      end
    end
    drain(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
